instr_prefetch_unit: RTL and testbench

//  Parametrised successor to the single-cycle fetch unit. Fetches instructions from a

---
 rtl/instr_prefetch_unit.sv | 150 +++++++++++++++
 tb/tb_instr_prefetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch unit: fetches from variable-latency imem into a small queue
// and presents {pc, instr} to decode; redirects flush wrong-path work.
module instr_prefetch_unit #(
   parameter int                 ADDR_W   = 32,
   parameter int                 DEPTH    = 4,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic                       imem_req,
   output logic [ADDR_W-1:0]          imem_addr,
   input  logic                       imem_ack,
   input  logic [31:0]                imem_rdata,
   output logic                       inst_valid,
   input  logic                       inst_ready,
   output logic [31:0]                inst_data,
   output logic [ADDR_W-1:0]          inst_pc,
   input  logic                       redir_valid,
   input  logic [1:0]                 redir_kind,
   input  logic [ADDR_W-1:0]          redir_pc,
   input  logic [15:0]                redir_imm16,
   input  logic [25:0]                redir_jtarget,
   input  logic [ADDR_W-1:0]          redir_reg,
   output logic [$clog2(DEPTH):0]     queue_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, STALE} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] fetch_pc_q;
   logic [ADDR_W-1:0] req_addr_q;
   logic              req_q;
   logic [PW-1:0]     wr_ptr_q;
   logic [PW-1:0]     rd_ptr_q;
   logic [CW-1:0]     count_q;

   logic [31:0]       data_mem [DEPTH];
   logic [ADDR_W-1:0] pc_mem   [DEPTH];

   logic              redir_act;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] pc4;
   logic [ADDR_W-1:0] branch_tgt;
   logic [ADDR_W-1:0] jump_tgt;
   logic [ADDR_W-1:0] jr_tgt;
   logic [ADDR_W-1:0] target_d;

   assign redir_act  = redir_valid && (redir_kind != 2'b11);
   assign pc4        = redir_pc + ADDR_W'(4);
   assign branch_tgt = pc4 + {{(ADDR_W-18){redir_imm16[15]}}, redir_imm16, 2'b00};
   assign jr_tgt     = redir_reg & ~ADDR_W'(3);

   // Narrow configurations have no upper PC bits left to carry into a jump target.
   if (ADDR_W > 28) begin : g_jump_hi
      assign jump_tgt = {pc4[ADDR_W-1:28], redir_jtarget, 2'b00};
   end else begin : g_jump_lo
      assign jump_tgt = {redir_jtarget, 2'b00};
   end

   always_comb begin
      target_d = branch_tgt;
      case (redir_kind)
         2'b01:   target_d = jump_tgt;
         2'b10:   target_d = jr_tgt;
         default: target_d = branch_tgt;
      endcase
   end

   // A redirect voids both the in-flight enqueue and any same-cycle dequeue.
   assign push = (state_q == WAIT) && imem_ack && !redir_act;
   assign pop  = (count_q != '0) && inst_ready && !redir_act;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         req_addr_q <= RESET_PC;
         req_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         if (redir_act) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
         end

         case (state_q)
            IDLE: begin
               if (redir_act) begin
                  fetch_pc_q <= target_d;
               end else if (count_q < DEPTH_C) begin
                  req_q      <= 1'b1;
                  req_addr_q <= fetch_pc_q;
                  state_q    <= WAIT;
               end
            end
            WAIT: begin
               if (redir_act) begin
                  fetch_pc_q <= target_d;
                  if (imem_ack) begin
                     req_q   <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     state_q <= STALE;
                  end
               end else if (imem_ack) begin
                  req_q      <= 1'b0;
                  fetch_pc_q <= fetch_pc_q + ADDR_W'(4);
                  state_q    <= IDLE;
               end
            end
            STALE: begin
               // Request stays asserted until imem answers; the answer is thrown away.
               if (redir_act) fetch_pc_q <= target_d;
               if (imem_ack) begin
                  req_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr_q] <= imem_rdata;
         pc_mem[wr_ptr_q]   <= req_addr_q;
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = req_addr_q;
   assign inst_valid  = (count_q != '0);
   assign inst_data   = data_mem[rd_ptr_q];
   assign inst_pc     = pc_mem[rd_ptr_q];
   assign queue_count = count_q;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed bench for instr_prefetch_unit: sequential fetch, backpressure, redirects,
// wrap-around and reset during an outstanding request.
module tb_instr_prefetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        redir_valid;
   logic [1:0]  redir_kind;
   logic [31:0] redir_pc;
   logic [15:0] redir_imm16;
   logic [25:0] redir_jtarget;
   logic [31:0] redir_reg;
   logic [2:0]  queue_count;

   int nchecks = 0;
   int nerr    = 0;
   bit auto_ack = 0;
   int wait_cnt = 0;

   instr_prefetch_unit #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
      .redir_valid(redir_valid), .redir_kind(redir_kind), .redir_pc(redir_pc),
      .redir_imm16(redir_imm16), .redir_jtarget(redir_jtarget), .redir_reg(redir_reg),
      .queue_count(queue_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (auto_ack) begin
         if (imem_ack) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
         end else if (imem_req) begin
            wait_cnt++;
            if (wait_cnt >= 2) begin
               imem_ack   = 1'b1;
               imem_rdata = mem_word(imem_addr);
            end
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b0; auto_ack = 0; imem_ack = 1'b0; redir_valid = 1'b0; wait_cnt = 0;
      tick(); tick();
      reset = 1'b1;
   endtask

   task automatic ack_once(input logic [31:0] d);
      imem_ack = 1'b1; imem_rdata = d;
      tick();
      imem_ack = 1'b0;
   endtask

   task automatic redirect(input logic [1:0] k, input logic [31:0] pc, input logic [15:0] imm,
                           input logic [25:0] jt, input logic [31:0] rg);
      redir_valid = 1'b1; redir_kind = k; redir_pc = pc;
      redir_imm16 = imm; redir_jtarget = jt; redir_reg = rg;
   endtask

   initial begin
      logic [31:0] exp_pc;
      int got, acks, n;
      reset = 1'b0; imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
      redir_valid = 1'b0; redir_kind = 2'b00; redir_pc = '0; redir_imm16 = '0;
      redir_jtarget = '0; redir_reg = '0;
      #12;
      check("rst_req", imem_req, 0);
      check("rst_valid", inst_valid, 0);
      check("rst_count", queue_count, 0);

      // Sequential fetch with 2-cycle imem latency
      do_reset();
      check("t1_req_held_low", imem_req, 0);
      inst_ready = 1'b1; auto_ack = 1;
      tick();
      check("t1_first_req", imem_req, 1);
      check("t1_first_addr", imem_addr, 32'h0);
      exp_pc = 32'h0; got = 0; n = 0;
      while (got < 3 && n < 60) begin
         tick(); n++;
         if (inst_valid && inst_ready) begin
            check("t1_pc", inst_pc, exp_pc);
            check("t1_data", inst_data, mem_word(exp_pc));
            $display("deq pc=%h data=%h", inst_pc, inst_data);
            exp_pc += 32'd4; got++;
         end
      end
      check("t1_got3", got, 3);

      // Backpressure: queue fills to DEPTH and fetching stops
      do_reset();
      inst_ready = 1'b0; auto_ack = 1; acks = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (imem_ack) acks++;
      end
      check("t2_acks", acks, 4);
      check("t2_req", imem_req, 0);
      check("t2_count", queue_count, 4);
      check("t2_head_pc", inst_pc, 32'h0);
      check("t2_head_data", inst_data, mem_word(32'h0));
      redirect(2'b11, 32'h40, 16'hFFFF, 26'h0, 32'h0);
      tick();
      redir_valid = 1'b0;
      check("t2_reserved_ignored", queue_count, 4);
      inst_ready = 1'b1; n = 0;
      while (!imem_req && n < 10) begin tick(); n++; end
      check("t2_resume_req", imem_req, 1);
      check("t2_resume_addr", imem_addr, 32'h10);

      // Branch redirects
      do_reset();
      inst_ready = 1'b0; auto_ack = 1; n = 0;
      while (!(queue_count == 3'd4 && !imem_req) && n < 60) begin tick(); n++; end
      auto_ack = 0; imem_ack = 1'b0;
      check("t3_full", queue_count, 4);
      redirect(2'b00, 32'h40, 16'hFFFF, 26'h0, 32'h0);
      tick();
      redir_valid = 1'b0;
      check("t3_flush_count", queue_count, 0);
      check("t3_flush_valid", inst_valid, 0);
      check("t3_no_req_yet", imem_req, 0);
      tick();
      check("t3_b1_req", imem_req, 1);
      check("t3_b1_addr", imem_addr, 32'h40);
      tick();
      redirect(2'b00, 32'h40, 16'h0003, 26'h0, 32'h0);
      tick();
      redir_valid = 1'b0;
      check("t3_stale_req_held", imem_req, 1);
      check("t3_stale_addr_held", imem_addr, 32'h40);
      ack_once(32'h1234_5678);
      check("t3_stale_done_req", imem_req, 0);
      check("t3_stale_dropped", queue_count, 0);
      tick();
      check("t3_b2_addr", imem_addr, 32'h50);

      // Jump while a request to 0x20 is outstanding
      redirect(2'b10, 32'h0, 16'h0, 26'h0, 32'h20);
      tick();
      redir_valid = 1'b0;
      ack_once(32'hDEAD_0050);
      tick();
      check("t4_req20", imem_req, 1);
      check("t4_addr20", imem_addr, 32'h20);
      redirect(2'b01, 32'h20, 16'h0, 26'h100, 32'h0);
      tick();
      redir_valid = 1'b0;
      inst_ready = 1'b1;
      ack_once(32'hBAD0_0020);
      check("t4_not_presented", inst_valid, 0);
      check("t4_count", queue_count, 0);
      tick();
      check("t4_jump_addr", imem_addr, 32'h400);
      check("t4_still_empty", inst_valid, 0);

      // JR with ack in the same cycle, then sequential wrap past the top of memory
      redirect(2'b10, 32'h0, 16'h0, 26'h0, 32'h1003);
      imem_ack = 1'b1; imem_rdata = 32'hBAD0_0400;
      tick();
      redir_valid = 1'b0; imem_ack = 1'b0;
      check("t5_req_drop", imem_req, 0);
      check("t5_valid_drop", inst_valid, 0);
      tick();
      check("t5_jr_addr", imem_addr, 32'h1000);
      redirect(2'b10, 32'h0, 16'h0, 26'h0, 32'hFFFF_FFFC);
      imem_ack = 1'b1;
      tick();
      redir_valid = 1'b0; imem_ack = 1'b0;
      tick();
      check("t5_top_addr", imem_addr, 32'hFFFF_FFFC);
      ack_once(mem_word(32'hFFFF_FFFC));
      check("t5_top_valid", inst_valid, 1);
      check("t5_top_pc", inst_pc, 32'hFFFF_FFFC);
      check("t5_top_data", inst_data, mem_word(32'hFFFF_FFFC));
      tick();
      check("t5_wrap_req", imem_req, 1);
      check("t5_wrap_addr", imem_addr, 32'h0);

      // Reset during WAIT, then a stale ack arrives after release
      reset = 1'b0;
      #1;
      check("t6_async_req", imem_req, 0);
      check("t6_async_valid", inst_valid, 0);
      check("t6_async_count", queue_count, 0);
      tick();
      reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0000;
      tick();
      imem_ack = 1'b0;
      check("t6_no_enqueue", queue_count, 0);
      check("t6_valid", inst_valid, 0);
      check("t6_req", imem_req, 1);
      check("t6_addr", imem_addr, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule
